// File: rtl/uart_pkg.sv
// uart_pkg: constants, state encoding and baud-select encoding shared by
// the UART receive and transmit paths.
package uart_pkg;

    localparam int OVERSAMPLE   = 16;
    localparam int DATA_BITS    = 8;
    localparam int START_SAMPLE = 8;

    localparam logic [1:0] BAUD_9600   = 2'd0;
    localparam logic [1:0] BAUD_19200  = 2'd1;
    localparam logic [1:0] BAUD_57600  = 2'd2;
    localparam logic [1:0] BAUD_115200 = 2'd3;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_t;

endpackage

// File: rtl/rx_baud_gen.sv
// rx_baud_gen: 16x oversample tick divider, restartable so ticks are
// phase-aligned to the start-bit edge.
module rx_baud_gen
    import uart_pkg::*;
#(
    parameter int DIV_0 = 326,
    parameter int DIV_1 = 163,
    parameter int DIV_2 = 54,
    parameter int DIV_3 = 27
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic [1:0] select,
    input  logic       restart,
    input  logic       enable,
    output logic       tick
);

    localparam int MAX_01  = (DIV_0 > DIV_1) ? DIV_0 : DIV_1;
    localparam int MAX_23  = (DIV_2 > DIV_3) ? DIV_2 : DIV_3;
    localparam int MAX_DIV = (MAX_01 > MAX_23) ? MAX_01 : MAX_23;
    localparam int CW      = $clog2(MAX_DIV);

    logic [CW-1:0] cnt;
    logic [CW-1:0] reload;

    always_comb begin
        reload = CW'(DIV_3 - 1);
        case (select)
            BAUD_9600:   reload = CW'(DIV_0 - 1);
            BAUD_19200:  reload = CW'(DIV_1 - 1);
            BAUD_57600:  reload = CW'(DIV_2 - 1);
            BAUD_115200: reload = CW'(DIV_3 - 1);
            default:     reload = CW'(DIV_3 - 1);
        endcase
    end

    assign tick = enable && (cnt == '0);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cnt <= '0;
        end else if (restart || !enable || cnt == '0) begin
            cnt <= reload;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 receiver with 16x oversampling, one-entry holding
// register and framing/overrun error pulses.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DIV_0 = 326,
    parameter int DIV_1 = 163,
    parameter int DIV_2 = 54,
    parameter int DIV_3 = 27
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       uart_rx_i,
    input  logic [1:0] baudrate_select_i,
    input  logic       data_read_i,
    output logic [7:0] data_o,
    output logic       data_valid_o,
    output logic       framing_error_o,
    output logic       overrun_error_o
);

    rx_state_t state, state_nxt;

    logic       rx_meta, rx_s, rx_prev;
    logic [1:0] sel_q, sel_eff;
    logic [3:0] tcnt;
    logic [2:0] bidx;
    logic [7:0] shreg;
    logic       tick, start_edge, start_hit, bit_hit;
    logic       restart, enable, go_data, shift;
    logic       stop_ok, stop_bad, do_load, do_overrun;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx_i;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign start_edge = ~rx_s & rx_prev;
    assign start_hit  = tick && tcnt == 4'(START_SAMPLE - 1);
    assign bit_hit    = tick && tcnt == 4'(OVERSAMPLE - 1);

    // Reload uses the live select on the start edge, the latched one after.
    assign sel_eff = (state == RX_IDLE) ? baudrate_select_i : sel_q;

    rx_baud_gen #(
        .DIV_0(DIV_0),
        .DIV_1(DIV_1),
        .DIV_2(DIV_2),
        .DIV_3(DIV_3)
    ) u_baud (
        .clock_i(clock_i),
        .reset_i(reset_i),
        .select (sel_eff),
        .restart(restart),
        .enable (enable),
        .tick   (tick)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) state <= RX_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RX_IDLE:
                if (start_edge) state_nxt = RX_START;
            RX_START:
                if (start_hit) state_nxt = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:
                if (bit_hit && bidx == 3'(DATA_BITS - 1)) state_nxt = RX_STOP;
            RX_STOP:
                if (bit_hit) state_nxt = rx_s ? RX_IDLE : RX_WAIT_IDLE;
            RX_WAIT_IDLE:
                if (rx_s) state_nxt = RX_IDLE;
            default:
                state_nxt = RX_IDLE;
        endcase
    end

    always_comb begin
        restart  = 1'b0;
        enable   = 1'b0;
        go_data  = 1'b0;
        shift    = 1'b0;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        unique case (state)
            RX_IDLE: restart = start_edge;
            RX_START: begin
                enable  = 1'b1;
                go_data = start_hit & ~rx_s;
            end
            RX_DATA: begin
                enable = 1'b1;
                shift  = bit_hit;
            end
            RX_STOP: begin
                enable   = 1'b1;
                stop_ok  = bit_hit & rx_s;
                stop_bad = bit_hit & ~rx_s;
            end
            default: ;
        endcase
    end

    // A same-cycle read frees the register, so the new byte is not an overrun.
    assign do_load    = stop_ok & (~data_valid_o | data_read_i);
    assign do_overrun = stop_ok & data_valid_o & ~data_read_i;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            sel_q <= 2'd0;
            tcnt  <= 4'd0;
            bidx  <= 3'd0;
            shreg <= 8'h00;
        end else begin
            if (restart) begin
                sel_q <= baudrate_select_i;
                tcnt  <= 4'd0;
            end else if (go_data) begin
                tcnt <= 4'd0;
                bidx <= 3'd0;
            end else if (tick) begin
                tcnt <= tcnt + 4'd1;
            end
            if (shift) begin
                shreg <= {rx_s, shreg[7:1]};
                bidx  <= bidx + 3'd1;
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            data_o          <= 8'h00;
            data_valid_o    <= 1'b0;
            framing_error_o <= 1'b0;
            overrun_error_o <= 1'b0;
        end else begin
            framing_error_o <= stop_bad;
            overrun_error_o <= do_overrun;
            if (do_load) begin
                data_o       <= shreg;
                data_valid_o <= 1'b1;
            end else if (data_read_i) begin
                data_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receive stage: the counterpart that consumes the line driven by the transmit path's `uart_tx_o`. It synchronises the asynchronous `uart_rx_i` line and samples 8N1 frames with 16x oversampling. Each received byte is presented in a one-entry holding register with a valid/read handshake, and the block reports framing and overrun errors. It shares baud-select encoding and rate with the transmit path, so a loopback of transmitter to receiver is lossless.

## Interface
- `DIV_0`, default 326: clocks per oversample tick for `baudrate_select_i` = 0 (9600 baud at 50 MHz).
- `DIV_1`, default 163: clocks per tick for select 1 (19200 baud).
- `DIV_2`, default 54: clocks per tick for select 2 (57600 baud).
- `DIV_3`, default 27: clocks per tick for select 3 (115200 baud).
- `clock_i`  in  1: single clock; all logic is on the rising edge.
- `reset_i`  in  1: asynchronous, active-high reset.
- `uart_rx_i`  in  1: asynchronous serial line; idles high.
- `baudrate_select_i`  in  2: rate select; sampled at start-bit detection.
- `data_read_i`  in  1: consumer pops the holding register. Ignored when `data_valid_o` = 0.
- `data_o`  out  8: received byte; stable while `data_valid_o` = 1.
- `data_valid_o`  out  1: level; the holding register is full.
- `framing_error_o`  out  1: one-cycle pulse when the stop bit is sampled low.
- `overrun_error_o`  out  1: one-cycle pulse when a good byte completes while the holding register is full.

## Operation
- **Synchroniser.** Two flops on `uart_rx_i`, both reset to 1. All logic uses the second-stage output `rx_s`.
- **Tick generator.**
  - Down-counter loaded with `DIV_n - 1`, where `DIV_n` is selected by the latched select.
  - Emits `tick` when it reaches 0, then reloads.
  - Held at reload value in IDLE; reloaded on the start-bit edge so ticks are phase-aligned to the edge.
  - Counter width is `$clog2(max DIV)`.
- **FSM.** States are IDLE, START, DATA, STOP, WAIT_IDLE. A 4-bit tick counter `tcnt` and a 3-bit bit index `bidx` are used.
  - IDLE: `rx_s` = 0 (falling edge versus previous `rx_s` = 1) latches `baudrate_select_i`, clears `tcnt`, and goes to START.
  - START: on the 8th tick (mid start bit), sample `rx_s`.
    - 1: glitch; return to IDLE with no flag.
    - 0: clear `tcnt` and `bidx`, go to DATA.
  - DATA: on every 16th tick, shift `rx_s` into the shift register LSB-first. After `bidx` = 7, go to STOP.
  - STOP: on the 16th tick, sample `rx_s`.
    - 1 with holding register empty: load `data_o` and set `data_valid_o`; go to IDLE.
    - 1 with holding register full: pulse `overrun_error_o`, discard the new byte, keep the old byte; go to IDLE.
    - 0: pulse `framing_error_o`, discard the byte; go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rx_s` = 1, then go to IDLE. This prevents a break from being taken as repeated frames.
- **Holding register.**
  - `data_read_i` with `data_valid_o` = 1 clears valid on the next edge.
  - If a read and a stop-bit-good load occur in the same cycle, the load wins: the new byte is written, valid stays 1, and there is no overrun.
- **Select changes.** A change of `baudrate_select_i` mid-frame has no effect until the next start bit.

## Timing
- **Reset values:**
  - `data_o` = 0x00, `data_valid_o` = 0, both error outputs 0.
  - FSM in IDLE; synchroniser = 1.
- **Reset mid-frame:** aborts the frame immediately; no flag. The partially received byte is never delivered.
- **Latency:**
  - `uart_rx_i` to `rx_s` is 2 clocks.
  - The stop-bit mid-sample tick to `data_valid_o` high is 1 clock, registered. The error pulses use the same clock.
- **Frame duration:** the stop sample falls 9.5 bit periods (152 ticks) after start detection. A new start edge is accepted from the cycle after the return to IDLE, which is half a stop bit of margin.
- **Output stability:** `data_o` changes only on a load; it is never modified while valid unless a same-cycle read and load occurs.

## Structure
- **Package `uart_pkg`:**
  - FSM state enum `rx_state_t`.
  - Oversample constant `OVERSAMPLE` = 16.
  - Frame constants `DATA_BITS` = 8 and `START_SAMPLE` = 8.
  - Baud-select encoding, shared with the transmit baud generator.
- **Sub-module `rx_baud_gen`:** the tick divider, with ports `clock_i`, `reset_i`, `select`, `restart`, `enable`, `tick`. The FSM, synchroniser and holding register live in `uart_receiver`.

## Test plan
All scenarios run with `DIV_3` = 4 and select = 3, so one bit is 64 clocks.
- **Single byte:** drive frame 0x55 → `data_o` = 0x55 and `data_valid_o` = 1 exactly 1 clock after the stop mid-sample; `data_read_i` pulse → valid = 0 next clock.
- **Glitch:** 20-clock low pulse on an idle line → FSM returns to IDLE; no valid, no error.
- **Framing error:** frame 0xA3 with stop bit = 0, held low for 3 bit times → one `framing_error_o` pulse and no valid. Then frame 0x3C after the line rises → `data_o` = 0x3C.
- **Overrun:** frames 0x11 then 0x22 back-to-back with no reads → `data_o` stays 0x11 and `overrun_error_o` pulses once. Repeat with `data_read_i` asserted in the same cycle as the second load → `data_o` = 0x22, valid stays 1, no overrun.
- **Reset mid-frame:** assert `reset_i` during bit 4 of frame 0xFF → all outputs 0 immediately. Next frame 0x81 → `data_o` = 0x81.
- **Loopback:** the transmit path sends 0x00, 0xFF, 0x5A at select 0–3 with default DIVs → identical bytes received in order, no errors.
